// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction read port (i_*)
// and a data read/write port (d_*). One transaction is in flight at a time:
// IDLE arbitrates and latches the winner, MEM holds the pmem strobe until
// pmem_resp, DONE pulses the owner's resp for one cycle.
//
// Ports
//   clk, rst_n       : clock, synchronous active-low reset
//   i_read/i_address : instruction read request (held until i_resp)
//   i_rdata/i_resp   : instruction read data and one-cycle completion pulse
//   d_read/d_write   : data request (held until d_resp); write wins if both set
//   d_address/d_wdata/d_wmask : data request payload
//   d_rdata/d_resp   : data read value and one-cycle completion pulse
//   pmem_*           : shared memory strobes/payload; pmem_rdata/pmem_resp back
//
// Parameter FAIR: 1 = alternate grants on contention, 0 = data port always wins.
module mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state;
  logic   owner;       // port that owns the in-flight transaction
  logic   last_grant;  // port granted most recently (fairness history)
  logic   d_req_c;
  logic   grant_c;

  // Arbitration decision for the current IDLE cycle
  always_comb begin
    d_req_c = d_read | d_write;
    grant_c = GRANT_I;
    if (d_req_c && i_read) begin
      grant_c = FAIR ? ~last_grant : GRANT_D;
    end else if (d_req_c) begin
      grant_c = GRANT_D;
    end
  end

  // Transaction FSM with registered memory strobes, payload and responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= GRANT_I;
      last_grant   <= GRANT_I;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read || d_req_c) begin
            owner      <= grant_c;
            last_grant <= grant_c;
            state      <= MEM;
            if (grant_c == GRANT_D) begin
              // a simultaneous d_read is dropped when d_write is set
              pmem_address <= d_address;
              pmem_write   <= d_write;
              pmem_read    <= ~d_write;
              pmem_wdata   <= d_write ? d_wdata : '0;
              pmem_wmask   <= d_write ? d_wmask : 4'b0000;
            end else begin
              pmem_address <= i_address;
              pmem_read    <= 1'b1;
              pmem_write   <= 1'b0;
              pmem_wdata   <= '0;
              pmem_wmask   <= 4'b0000;
            end
          end
        end
        MEM: begin
          if (pmem_resp) begin
            if (pmem_read) begin
              if (owner == GRANT_D) d_rdata <= pmem_rdata;
              else                  i_rdata <= pmem_rdata;
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            i_resp     <= (owner == GRANT_I);
            d_resp     <= (owner == GRANT_D);
            state      <= DONE;
          end
        end
        DONE: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
